debounc_arbiter: RTL and testbench



---
 rtl/debounc_pkg.sv | 24 ++
 rtl/debounc_arbiter_rr_pick.sv | 30 +++
 rtl/debounc_arbiter.sv | 160 ++++++++++++++++
 tb/tb_debounc_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounc_pkg.sv
// Shared definitions for the shared-timer button debouncer: state encoding,
// default qualification time and a constant clog2 used for parameter checks.
package debounc_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_COUNT  = S_COUNT,
        ST_COMMIT = S_COMMIT
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/debounc_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr_i+1 with wrap-around.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_req_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        idx         = 0;
        found       = 1'b0;
        grant_idx_o = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[IDX_W'(idx)]) begin
                found       = 1'b1;
                grant_idx_o = IDX_W'(idx);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/debounc_arbiter.sv
// N_BOT active-low buttons debounced through one shared, round-robin granted
// timer. Optional long-press detector enabled by DEBOUNC_LONGPRESS_EN.
//   state  | meaning
//   IDLE   | timer free, pick next button whose synced level differs
//   COUNT  | qualifying the granted button, abort if it bounces back
//   COMMIT | update stable level and load event (stalls on a full holder)
module debounc_arbiter
    import debounc_pkg::*;
#(
    parameter int N_BOT           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter int IDX_W           = 2
`ifdef DEBOUNC_LONGPRESS_EN
    , parameter int LONG_CYCLES   = 50000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BOT-1:0] bot,
    output logic [N_BOT-1:0] bot_trat,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_idx,
    output logic             ev_press,
    output logic             busy
`ifdef DEBOUNC_LONGPRESS_EN
    , output logic             long_valid
    , output logic [IDX_W-1:0] long_idx
`endif
);

    if (IDX_W != clog2(N_BOT)) begin : g_bad_idx_w
        $error("IDX_W must equal clog2(N_BOT)");
    end
    if (clog2(DEBOUNCE_CYCLES + 1) > CNT_W) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (DEBOUNCE_CYCLES < 2 || N_BOT < 2 || N_BOT > 16) begin : g_bad_range
        $error("DEBOUNCE_CYCLES or N_BOT out of range");
    end

    localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BOT-1:0] sync1_q, bs_q, bot_trat_q, req;
    state_t           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [IDX_W-1:0] ptr_q, sel_q, grant_idx;
    logic             any_req;
    logic             ev_valid_q, ev_valid_d, ev_press_q;
    logic [IDX_W-1:0] ev_idx_q;
    logic             req_sel, stall, pop, commit_go;

    assign req       = bs_q ^ bot_trat_q;
    assign req_sel   = req[sel_q];
    assign pop       = ev_valid_q & ev_ready;
    assign stall     = ev_valid_q & ~ev_ready;
    assign commit_go = (state_q == ST_COMMIT) & ~stall & req_sel;
    // A commit on the same edge as a pop replaces the popped event.
    assign ev_valid_d = commit_go | (ev_valid_q & ~pop);

    rr_pick #(.N(N_BOT), .IDX_W(IDX_W)) u_rr_pick (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .grant_idx_o (grant_idx),
        .any_req_o   (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '1;
            bs_q       <= '1;
            bot_trat_q <= '1;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            ptr_q      <= IDX_W'(N_BOT - 1);
            sel_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_idx_q   <= '0;
            ev_press_q <= 1'b0;
        end else begin
            sync1_q    <= bot;
            bs_q       <= sync1_q;
            ev_valid_q <= ev_valid_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        sel_q   <= grant_idx;
                        timer_q <= '0;
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!req_sel) begin
                        ptr_q   <= sel_q;
                        state_q <= ST_IDLE;
                    end else if (timer_q == TC) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if (!stall) begin
                        if (req_sel) begin
                            bot_trat_q[sel_q] <= bs_q[sel_q];
                            ev_idx_q          <= sel_q;
                            ev_press_q        <= ~bs_q[sel_q];
                        end
                        ptr_q   <= sel_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bot_trat = bot_trat_q;
    assign ev_valid = ev_valid_q;
    assign ev_idx   = ev_idx_q;
    assign ev_press = ev_press_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef DEBOUNC_LONGPRESS_EN
    localparam int LONG_W = clog2(LONG_CYCLES + 1);

    logic [LONG_W-1:0] long_cnt_q;
    logic              long_armed_q, long_valid_q;
    logic [IDX_W-1:0]  long_idx_q;

    // Any committed change restarts the count; only a press re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt_q   <= '0;
            long_armed_q <= 1'b0;
            long_valid_q <= 1'b0;
            long_idx_q   <= '0;
        end else begin
            long_valid_q <= 1'b0;
            if (commit_go) begin
                long_cnt_q   <= '0;
                long_armed_q <= ~bs_q[sel_q];
                if (!bs_q[sel_q]) long_idx_q <= sel_q;
            end else if (long_armed_q && !bot_trat_q[long_idx_q]) begin
                if (long_cnt_q == LONG_W'(LONG_CYCLES - 1)) begin
                    long_valid_q <= 1'b1;
                    long_armed_q <= 1'b0;
                end else begin
                    long_cnt_q <= long_cnt_q + LONG_W'(1);
                end
            end
        end
    end

    assign long_valid = long_valid_q;
    assign long_idx   = long_idx_q;
`endif

endmodule

// File: tb/tb_debounc_arbiter.sv
// Self-checking bench for debounc_arbiter: vector table, hand-written corner
// sequences, and random button activity against a behavioural model.
module tb_debounc_arbiter;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int CW = 20;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst, ev_ready, ev_valid, ev_press, busy;
    logic [N-1:0]  bot, bot_trat;
    logic [IW-1:0] ev_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    debounc_arbiter #(
        .N_BOT(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .IDX_W(IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bot      (bot),
        .bot_trat (bot_trat),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_idx   (ev_idx),
        .ev_press (ev_press),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample 2 time units after the rising edge; inputs are driven right after.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input logic [N-1:0] b, input logic rdy);
        rst = 1'b1; bot = b; ev_ready = rdy;
        tick(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  bot;
        logic          rdy;
        int            cycles;
        logic [N-1:0]  trat;
        logic          v;
        logic [IW-1:0] idx;
        logic          p;
        logic          b;
    } vec_t;

    vec_t tbl[12];

    // Random-phase reference model state
    logic [N-1:0] model_stable;
    logic [N-1:0] hist[$];
    logic         prev_v, prev_p;
    logic [IW-1:0] prev_idx;
    int           n_ev;

    task automatic monitor();
        logic newlvl, ok;
        int   last;
        hist.push_back(bot);
        if (prev_v && !ev_ready) begin
            chk("rnd_hold_valid", 32'(ev_valid), 32'd1);
            chk("rnd_hold_idx", 32'(ev_idx), 32'(prev_idx));
            chk("rnd_hold_press", 32'(ev_press), 32'(prev_p));
        end else if (ev_valid) begin
            n_ev++;
            chk("rnd_press", 32'(ev_press), 32'(model_stable[ev_idx]));
            newlvl = ~model_stable[ev_idx];
            ok = 1'b1;
            last = hist.size() - 1;
            if (hist.size() < D + 4) ok = 1'b0;
            else
                for (int k = 2; k <= D + 3; k++)
                    if (hist[last - k][ev_idx] !== newlvl) ok = 1'b0;
            chk("rnd_qualified", 32'(ok), 32'd1);
            model_stable[ev_idx] = newlvl;
        end
        chk("rnd_trat", 32'(bot_trat), 32'(model_stable));
        prev_v = ev_valid; prev_idx = ev_idx; prev_p = ev_press;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_c, second_c;
        logic [IW-1:0] first_i, second_i;
        logic first_p, second_p, pv;

        rst = 1'b1; bot = '0; ev_ready = 1'b0;

        //          rst  bot      rdy cyc  trat     v  idx p  busy
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 2,  4'b1111, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4,  4'b1111, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b1011, 1'b0, 11, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 4'b1011, 1'b0, 1,  4'b1011, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'b1011, 1'b0, 5,  4'b1011, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'b1011, 1'b1, 1,  4'b1011, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 12, 4'b1111, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1,  4'b1111, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b1101, 1'b1, 5,  4'b1111, 1'b0, 2'd2, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 2,  4'b1111, 1'b0, 2'd2, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 1,  4'b1111, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 12, 4'b1111, 1'b0, 2'd2, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; bot = tbl[i].bot; ev_ready = tbl[i].rdy;
            tick(tbl[i].cycles);
            chk($sformatf("vec%0d_trat", i), 32'(bot_trat), 32'(tbl[i].trat));
            chk($sformatf("vec%0d_valid", i), 32'(ev_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_idx", i), 32'(ev_idx), 32'(tbl[i].idx));
            chk($sformatf("vec%0d_press", i), 32'(ev_press), 32'(tbl[i].p));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].b));
        end

        // Simultaneous falls on buttons 0 and 3, consumer always ready
        do_reset(4'b1111, 1'b1);
        bot = 4'b0110;
        first_c = -1; second_c = -1; pv = 1'b0;
        first_i = '0; second_i = '0; first_p = 1'b0; second_p = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (ev_valid && !pv) begin
                if (first_c < 0) begin
                    first_c = c; first_i = ev_idx; first_p = ev_press;
                end else if (second_c < 0) begin
                    second_c = c; second_i = ev_idx; second_p = ev_press;
                end
            end
            pv = ev_valid;
        end
        chk("sim_first_cycle", 32'(first_c), 32'd12);
        chk("sim_first_idx", 32'(first_i), 32'd0);
        chk("sim_first_press", 32'(first_p), 32'd1);
        chk("sim_second_cycle", 32'(second_c), 32'd22);
        chk("sim_second_idx", 32'(second_i), 32'd3);
        chk("sim_second_press", 32'(second_p), 32'd1);
        chk("sim_trat", 32'(bot_trat), 32'(4'b0110));

        // Backpressure: second qualified press stalls in COMMIT
        do_reset(4'b1111, 1'b0);
        bot = 4'b0110;
        tick(12);
        chk("bp_first_valid", 32'(ev_valid), 32'd1);
        chk("bp_first_idx", 32'(ev_idx), 32'd0);
        chk("bp_first_trat", 32'(bot_trat), 32'(4'b1110));
        tick(18);
        chk("bp_stall_valid", 32'(ev_valid), 32'd1);
        chk("bp_stall_idx", 32'(ev_idx), 32'd0);
        chk("bp_stall_trat", 32'(bot_trat), 32'(4'b1110));
        chk("bp_stall_busy", 32'(busy), 32'd1);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        chk("bp_swap_valid", 32'(ev_valid), 32'd1);
        chk("bp_swap_idx", 32'(ev_idx), 32'd3);
        chk("bp_swap_press", 32'(ev_press), 32'd1);
        chk("bp_swap_trat", 32'(bot_trat), 32'(4'b0110));
        chk("bp_swap_busy", 32'(busy), 32'd0);
        tick(1);
        chk("bp_hold_idx", 32'(ev_idx), 32'd3);
        chk("bp_hold_valid", 32'(ev_valid), 32'd1);

        // Reset while counting: change is discarded, then requalified from scratch
        do_reset(4'b1111, 1'b1);
        bot = 4'b1011;
        tick(7);
        chk("rmc_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rmc_trat", 32'(bot_trat), 32'(4'b1111));
        chk("rmc_valid", 32'(ev_valid), 32'd0);
        chk("rmc_busy", 32'(busy), 32'd0);
        tick(11);
        chk("rmc_not_yet", 32'(ev_valid), 32'd0);
        chk("rmc_not_yet_trat", 32'(bot_trat), 32'(4'b1111));
        tick(1);
        chk("rmc_requal_valid", 32'(ev_valid), 32'd1);
        chk("rmc_requal_idx", 32'(ev_idx), 32'd2);
        chk("rmc_requal_trat", 32'(bot_trat), 32'(4'b1011));

        // Random button activity and random backpressure against the model
        do_reset(4'b1111, 1'b1);
        model_stable = '1;
        hist.delete();
        prev_v = 1'b0; prev_idx = '0; prev_p = 1'b0; n_ev = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 24) == 0) bot[b] = ~bot[b];
            ev_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #2;
            monitor();
        end
        ev_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            monitor();
        end
        chk("rnd_final_trat", 32'(bot_trat), 32'(bot));
        chk("rnd_final_valid", 32'(ev_valid), 32'd0);
        chk("rnd_final_busy", 32'(busy), 32'd0);
        chk("rnd_events_seen", 32'(n_ev >= 10), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
